// File: rtl/ram_port_arbiter_if.sv
// Requester/controller bundle for ram_port_arbiter.
// slave = arbiter side, master = core requesters plus RAM controller.
interface ram_port_arbiter_if #(
  parameter int ADDRESS_SIZE = 28,
  parameter int DATA_SIZE    = 32,
  parameter int MASK_SIZE    = DATA_SIZE/8
);
  logic                    p0_req, p0_we, p0_ack;
  logic [ADDRESS_SIZE-1:0] p0_addr;
  logic [MASK_SIZE-1:0]    p0_mask;
  logic [DATA_SIZE-1:0]    p0_wdata, p0_rdata;
  logic                    p1_req, p1_we, p1_ack;
  logic [ADDRESS_SIZE-1:0] p1_addr;
  logic [MASK_SIZE-1:0]    p1_mask;
  logic [DATA_SIZE-1:0]    p1_wdata, p1_rdata;
  logic [ADDRESS_SIZE-1:0] ram_address;
  logic [MASK_SIZE-1:0]    ram_mask;
  logic                    ram_write_trigger, ram_read_trigger;
  logic [DATA_SIZE-1:0]    ram_write_value, ram_read_value;
  logic                    ram_ready, ram_read_ready;
  logic [3:0]              ram_error;
  logic                    arb_error;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_mask, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_mask, p1_wdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output ram_address, ram_mask, ram_write_trigger, ram_read_trigger, ram_write_value,
    input  ram_ready, ram_read_value, ram_read_ready, ram_error,
    output arb_error
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_mask, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_mask, p1_wdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  ram_address, ram_mask, ram_write_trigger, ram_read_trigger, ram_write_value,
    output ram_ready, ram_read_value, ram_read_ready, ram_error,
    input  arb_error
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of one RAM controller user port.
// Optional WAIT watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter #(
  parameter int ADDRESS_SIZE   = 28,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE/8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e               state_q;
  logic                 last_grant_q, grant_q, we_q;
  logic                 seen_busy_q, latched_q, err_q;
  logic [DATA_SIZE-1:0] buf_q;
  logic                 any_req, win_d, done_d, tmo_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign any_req = bus.p0_req | bus.p1_req;
  // 1 selects port 1; on a tie the port that did not win last time goes
  assign win_d   = bus.p1_req & (~bus.p0_req | ~last_grant_q);
  assign done_d  = seen_busy_q & bus.ram_ready & (we_q | latched_q);

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= IDLE;
      last_grant_q          <= 1'b1;
      grant_q               <= 1'b0;
      we_q                  <= 1'b0;
      seen_busy_q           <= 1'b0;
      latched_q             <= 1'b0;
      err_q                 <= 1'b0;
      buf_q                 <= '0;
      bus.p0_ack            <= 1'b0;
      bus.p1_ack            <= 1'b0;
      bus.p0_rdata          <= '0;
      bus.p1_rdata          <= '0;
      bus.ram_address       <= '0;
      bus.ram_mask          <= '0;
      bus.ram_write_value   <= '0;
      bus.ram_write_trigger <= 1'b0;
      bus.ram_read_trigger  <= 1'b0;
      bus.arb_error         <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      tmo_q                 <= '0;
`endif
    end else begin
      bus.ram_write_trigger <= 1'b0;
      bus.ram_read_trigger  <= 1'b0;
      bus.p0_ack            <= 1'b0;
      bus.p1_ack            <= 1'b0;
      case (state_q)
        IDLE: if (any_req && bus.ram_ready) begin
          grant_q               <= win_d;
          last_grant_q          <= win_d;
          we_q                  <= win_d ? bus.p1_we : bus.p0_we;
          bus.ram_address       <= win_d ? bus.p1_addr  : bus.p0_addr;
          bus.ram_mask          <= win_d ? bus.p1_mask  : bus.p0_mask;
          bus.ram_write_value   <= win_d ? bus.p1_wdata : bus.p0_wdata;
          // triggers are registered here so they are high exactly in ISSUE
          bus.ram_write_trigger <= win_d ? bus.p1_we  : bus.p0_we;
          bus.ram_read_trigger  <= win_d ? ~bus.p1_we : ~bus.p0_we;
          state_q               <= ISSUE;
        end
        ISSUE: begin
          seen_busy_q <= 1'b0;
          latched_q   <= 1'b0;
          err_q       <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
          tmo_q       <= '0;
`endif
          state_q     <= WAIT;
        end
        WAIT: begin
          if (!bus.ram_ready) seen_busy_q <= 1'b1;
          if (bus.ram_read_ready) begin
            buf_q     <= bus.ram_read_value;
            latched_q <= 1'b1;
          end
          if (bus.ram_error != '0) begin
            err_q         <= 1'b1;
            bus.arb_error <= 1'b1;
          end
`ifdef RAM_ARB_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
`endif
          if (done_d || tmo_hit) begin
            if (grant_q) bus.p1_ack <= 1'b1;
            else         bus.p0_ack <= 1'b1;
            // errored or timed-out reads return zero, not stale buffer data
            if (!we_q) begin
              if (grant_q)
                bus.p1_rdata <= (err_q || tmo_hit || bus.ram_error != '0) ? '0 : buf_q;
              else
                bus.p0_rdata <= (err_q || tmo_hit || bus.ram_error != '0) ? '0 : buf_q;
            end
            if (tmo_hit) bus.arb_error <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: reactive controller model plus a
// transaction-level monitor predicting grants, acks, rdata and arb_error.
module tb_ram_port_arbiter;
  localparam int AW = 28, DW = 32, MW = 4;
`ifdef RAM_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic clk = 1'b0, reset = 1'b1;
  ram_port_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MASK_SIZE(MW)) bus();
  ram_port_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MASK_SIZE(MW), .TIMEOUT_CYCLES(TMO))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // controller model
  logic        force_en = 0, err_inject = 0, rand_err = 0, stall = 0;
  logic [31:0] force_data = 0, last_rdata = 0;
  int          lat_fix = 0, mcnt = 0;
  logic        m_rd = 0, m_err = 0, m_stall = 0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      bus.ram_ready = 1; bus.ram_read_ready = 0; bus.ram_error = 0;
      mcnt = 0; m_err = 0; m_stall = 0;
    end else begin
      bus.ram_read_ready = 0;
      if (bus.ram_read_trigger || bus.ram_write_trigger) begin
        bus.ram_ready = 0;
        mcnt    = (lat_fix != 0) ? lat_fix : $urandom_range(2, 5);
        m_rd    = bus.ram_read_trigger;
        m_err   = err_inject || (rand_err && $urandom_range(0, 7) == 0);
        m_stall = stall;
        bus.ram_error = m_err ? 4'd1 : 4'd0;
      end else if (mcnt > 0 && !m_stall) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.ram_ready = 1; bus.ram_error = 0;
          if (m_rd) begin
            last_rdata = force_en ? force_data : $urandom;
            bus.ram_read_value = last_rdata;
            bus.ram_read_ready = 1;
          end
        end
      end
    end
  end

  // transaction monitor / reference model
  int          cyc = 0, trig_cyc = 0, rd_trigs = 0, last_lat = 0;
  logic [1:0]  prev_req = 0;
  logic        last_m = 1, inflight = 0, cur_port = 0, cur_we = 0, arb_exp = 0, w;
  logic [31:0] hold [2];
  int          gq[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_m = 1; inflight = 0; arb_exp = 0; hold[0] = 0; hold[1] = 0;
    end else begin
      if (bus.ram_read_trigger || bus.ram_write_trigger) begin
        chk("one_trigger", bus.ram_read_trigger & bus.ram_write_trigger, 0);
        chk("trig_while_busy", inflight, 0);
        w = prev_req[1] & (~prev_req[0] | ~last_m);
        chk("grant_has_req", prev_req[w], 1);
        chk("trig_type", bus.ram_write_trigger, w ? bus.p1_we : bus.p0_we);
        chk("ram_address", bus.ram_address, w ? bus.p1_addr : bus.p0_addr);
        chk("ram_mask", bus.ram_mask, w ? bus.p1_mask : bus.p0_mask);
        if (bus.ram_write_trigger)
          chk("ram_wvalue", bus.ram_write_value, w ? bus.p1_wdata : bus.p0_wdata);
        else rd_trigs++;
        cur_port = w; cur_we = bus.ram_write_trigger; last_m = w;
        inflight = 1; trig_cyc = cyc; gq.push_back(int'(w));
      end
      if (bus.p0_ack || bus.p1_ack) begin
        chk("ack_overlap", bus.p0_ack & bus.p1_ack, 0);
        chk("ack_without_txn", inflight, 1);
        chk("ack_port", bus.p1_ack, cur_port);
        chk("latency", (cyc - trig_cyc) >= 3, 1);
        last_lat = cyc - trig_cyc;
        if (m_err || m_stall) arb_exp = 1;
        if (!cur_we) hold[cur_port] = (m_err || m_stall) ? 32'h0 : last_rdata;
        chk("p0_rdata", bus.p0_rdata, hold[0]);
        chk("p1_rdata", bus.p1_rdata, hold[1]);
        chk("arb_error", bus.arb_error, arb_exp);
        inflight = 0;
      end
      if (inflight && (cyc - trig_cyc) > 60) begin
        chk("ack_timeout", 0, 1);
        inflight = 0;
      end
    end
    prev_req = {bus.p1_req, bus.p0_req};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rq(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.p0_req = 1; bus.p0_we = we; bus.p0_addr = a; bus.p0_mask = 4'hF; bus.p0_wdata = d;
    end else begin
      bus.p1_req = 1; bus.p1_we = we; bus.p1_addr = a; bus.p1_mask = 4'hF; bus.p1_wdata = d;
    end
  endtask

  task automatic rand_rq(input int p);
    rq(p, 1'($urandom), AW'($urandom), $urandom);
    if (p == 0) bus.p0_mask = 4'($urandom); else bus.p1_mask = 4'($urandom);
  endtask

  task automatic wait_ack(input int p, input int lim, output logic ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (p == 0 ? bus.p0_ack : bus.p1_ack) begin ok = 1; break; end
    end
    step(1);
  endtask

  task automatic pulse_reset();
    reset = 1; step(1); reset = 0;
  endtask

  logic       ok, quiet;
  logic [1:0] ackd;
  int         n, r0;

  initial begin
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_mask = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_mask = 0; bus.p1_wdata = 0;
    bus.ram_ready = 1; bus.ram_read_value = 0; bus.ram_read_ready = 0; bus.ram_error = 0;
    step(3);
    @(negedge clk);
    chk("rst_acks", {bus.p1_ack, bus.p0_ack}, 0);
    chk("rst_triggers", {bus.ram_write_trigger, bus.ram_read_trigger}, 0);
    chk("rst_ram_bus", {bus.ram_address, bus.ram_mask}, 0);
    chk("rst_wvalue", bus.ram_write_value, 0);
    chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
    chk("rst_arb_error", bus.arb_error, 0);
    step(1); reset = 0;

    // single read on port 0
    force_en = 1; force_data = 32'hDEADBEEF; r0 = rd_trigs;
    rq(0, 0, 28'h10, 0); wait_ack(0, 50, ok); bus.p0_req = 0;
    chk("t1_ack", ok, 1);
    chk("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);
    @(negedge clk); chk("t1_single_ack", bus.p0_ack, 0);
    chk("t1_read_triggers", rd_trigs - r0, 1);
    step(1);

    // single write on port 1
    rq(1, 1, 28'h20, 32'h12345678); wait_ack(1, 50, ok); bus.p1_req = 0;
    chk("t2_ack", ok, 1);
    chk("t2_addr", bus.ram_address, 28'h20);
    chk("t2_wvalue", bus.ram_write_value, 32'h12345678);

    // contention: both held for four transactions
    pulse_reset(); gq.delete(); n = 0;
    rq(0, 0, 28'h100, 0); rq(1, 0, 28'h200, 0);
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) n++;
    end
    step(1); bus.p0_req = 0; bus.p1_req = 0;
    chk("t3_acks", n, 4);
    chk("t3_grants", gq.size(), 4);
    for (int k = 0; k < gq.size() && k < 4; k++) chk("t3_order", gq[k], k % 2);

    // controller error during port 1 read
    err_inject = 1;
    rq(1, 0, 28'h30, 0); wait_ack(1, 50, ok); bus.p1_req = 0; err_inject = 0;
    chk("t4_ack", ok, 1);
    chk("t4_rdata", bus.p1_rdata, 0);
    step(3); chk("t4_sticky", bus.arb_error, 1);
    pulse_reset(); @(negedge clk); chk("t4_cleared", bus.arb_error, 0); step(1);

    // reset while in WAIT
    lat_fix = 6; ok = 0;
    rq(0, 0, 28'h40, 0);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = bus.ram_read_trigger;
    end
    chk("t5_trigger", ok, 1);
    step(1); reset = 1; bus.p0_req = 0;
    step(1); reset = 0;
    @(negedge clk);
    chk("t5_idle_out", {bus.p0_ack, bus.p1_ack, bus.ram_read_trigger, bus.ram_write_trigger}, 0);
    quiet = 1;
    repeat (8) begin @(negedge clk); if (bus.p0_ack || bus.p1_ack) quiet = 0; end
    chk("t5_no_ack", quiet, 1);
    step(1); lat_fix = 0;
    rq(0, 0, 28'h44, 0); wait_ack(0, 50, ok); bus.p0_req = 0;
    chk("t5_recover", ok, 1);
    chk("t5_rdata", bus.p0_rdata, 32'hDEADBEEF);

    // randomized traffic on both ports
    force_en = 0; rand_err = 1; ackd = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 ? bus.p0_req : bus.p1_req) && ackd[p]) begin
          if ($urandom_range(0, 1) == 1) rand_rq(p);
          else if (p == 0) bus.p0_req = 0; else bus.p1_req = 0;
        end else if (!(p == 0 ? bus.p0_req : bus.p1_req) && $urandom_range(0, 3) == 0)
          rand_rq(p);
      end
      @(negedge clk); ackd = {bus.p1_ack, bus.p0_ack};
      step(1);
    end
    for (int c = 0; c < 200 && (bus.p0_req || bus.p1_req); c++) begin
      if (ackd[0]) bus.p0_req = 0;
      if (ackd[1]) bus.p1_req = 0;
      @(negedge clk); ackd = {bus.p1_ack, bus.p0_ack};
      step(1);
    end
    chk("drain", {bus.p1_req, bus.p0_req}, 0);
    rand_err = 0;

`ifdef RAM_ARB_TIMEOUT_EN
    // controller never returns ready
    pulse_reset(); stall = 1;
    rq(0, 0, 28'h50, 0); wait_ack(0, 60, ok); bus.p0_req = 0;
    chk("t6_ack", ok, 1);
    chk("t6_latency", last_lat, TMO + 1);
    chk("t6_rdata", bus.p0_rdata, 0);
    chk("t6_arb_error", bus.arb_error, 1);
    stall = 0; pulse_reset();
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
